// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout
//  Pixel-clock read side of the indexed framebuffer. Walks the 8-bit index RAM
//  in raster order with 2x pixel/line doubling, looks each index up in the
//  24-bit palette RAM and emits RGB with delay-matched syncs.
// Ports
//  clk_pixel, reset_n            pixel clock, synchronous active-low reset
//  output_enable                 display enable request, sampled at vsync rise
//  de_in, hsync_in, vsync_in     timing from the video timing generator
//  fb_rgb_addr / fb_rgb_data     index RAM read port (address out, index in)
//  fb_palette_addr / _data       palette RAM read port (index out, {R,G,B} in)
//  rgb_out, de_out, hsync_out,   pixel and syncs to the encoder, all delayed
//  vsync_out                     by LATENCY clocks
//  frame_start                   one-clock pulse on vsync_in rising edge
module framebuffer_scanout #(
   parameter int unsigned FB_WIDTH       = 320,
   parameter int unsigned FB_HEIGHT      = 240,
   parameter int unsigned H_ACTIVE       = 640,
   parameter int unsigned V_ACTIVE       = 480,
   parameter int unsigned FB_RD_LATENCY  = 1,
   parameter int unsigned PAL_RD_LATENCY = 1,
   parameter logic [23:0] BORDER_COLOR   = 24'h000000
) (
   input  logic        clk_pixel,
   input  logic        reset_n,
   input  logic        output_enable,
   input  logic        de_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic [16:0] fb_rgb_addr,
   input  logic [7:0]  fb_rgb_data,
   output logic [7:0]  fb_palette_addr,
   input  logic [23:0] fb_palette_data,
   output logic [23:0] rgb_out,
   output logic        de_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        frame_start
);

   localparam int unsigned LATENCY = 2 + FB_RD_LATENCY + PAL_RD_LATENCY;
   localparam int unsigned XW      = $clog2(H_ACTIVE + 1);
   localparam int unsigned YW      = $clog2(V_ACTIVE + 1);
   localparam int unsigned AW      = 17;

   localparam logic [XW-1:0] X_FB_END    = XW'(2 * FB_WIDTH);
   localparam logic [XW-1:0] X_ADDR_LAST = XW'(2 * FB_WIDTH - 1);
   localparam logic [YW-1:0] Y_FB_END    = YW'(2 * FB_HEIGHT);
   localparam logic [YW-1:0] Y_LAST_LINE = YW'(2 * FB_HEIGHT - 1);
   localparam logic [AW-1:0] ROW_STEP    = AW'(FB_WIDTH);

   typedef enum logic {
      WAIT_VSYNC = 1'b0,
      ACTIVE     = 1'b1
   } state_t;

   state_t              state;
   logic [XW-1:0]       x;
   logic [YW-1:0]       y;
   logic [AW-1:0]       row_base;
   logic                de_prev;
   logic                vs_prev;
   logic                enabled_q;
   logic [LATENCY-1:0]  de_pipe;
   logic [LATENCY-1:0]  hs_pipe;
   logic [LATENCY-1:0]  vs_pipe;
   logic [LATENCY-2:0]  fb_pipe;

   logic                vs_rise_c;
   logic                de_fall_c;
   logic                in_fb_c;
   logic [AW-1:0]       next_row_base_c;

   assign de_out    = de_pipe[LATENCY-1];
   assign hsync_out = hs_pipe[LATENCY-1];
   assign vsync_out = vs_pipe[LATENCY-1];

   // Edge detects and the row base for the next line (advances after the second copy).
   always_comb begin
      vs_rise_c       = vsync_in & ~vs_prev;
      de_fall_c       = de_prev & ~de_in;
      in_fb_c         = de_in && (x < X_FB_END) && (y < Y_FB_END);
      next_row_base_c = y[0] ? (row_base + ROW_STEP) : row_base;
   end

   // Sync FSM, address generation and the delay-matched read pipeline.
   always_ff @(posedge clk_pixel) begin
      if (!reset_n) begin
         state           <= WAIT_VSYNC;
         x               <= '0;
         y               <= '0;
         row_base        <= '0;
         fb_rgb_addr     <= '0;
         fb_palette_addr <= '0;
         de_prev         <= 1'b0;
         vs_prev         <= 1'b0;
         enabled_q       <= 1'b0;
         de_pipe         <= '0;
         hs_pipe         <= '0;
         vs_pipe         <= '0;
         fb_pipe         <= '0;
         frame_start     <= 1'b0;
         rgb_out         <= BORDER_COLOR;
      end else begin
         de_prev     <= de_in;
         vs_prev     <= vsync_in;
         frame_start <= vs_rise_c;

         de_pipe <= {de_pipe[LATENCY-2:0], de_in};
         hs_pipe <= {hs_pipe[LATENCY-2:0], hsync_in};
         vs_pipe <= {vs_pipe[LATENCY-2:0], vsync_in};
         fb_pipe <= {fb_pipe[LATENCY-3:0], in_fb_c};

         // Index RAM data is the palette address; palette data lands one stage before the output.
         fb_palette_addr <= fb_rgb_data;
         rgb_out <= (fb_pipe[LATENCY-2] && enabled_q && (state == ACTIVE)) ?
                    fb_palette_data : BORDER_COLOR;

         if (vs_rise_c) begin
            // Frame boundary: only point where the enable is sampled, so no mid-frame tearing.
            state       <= ACTIVE;
            enabled_q   <= output_enable;
            x           <= '0;
            y           <= '0;
            row_base    <= '0;
            fb_rgb_addr <= '0;
         end else if (de_in) begin
            if (x != '1) begin
               x <= x + XW'(1);
            end
            // Step after each odd pixel; stop on the row's last word and below the image.
            if (x[0] && (x < X_ADDR_LAST) && (y < Y_FB_END)) begin
               fb_rgb_addr <= fb_rgb_addr + AW'(1);
            end
         end else if (de_fall_c) begin
            x <= '0;
            if (y != '1) begin
               y <= y + YW'(1);
            end
            // Past the last image line the address holds at the final pixel.
            if (y < Y_LAST_LINE) begin
               row_base    <= next_row_base_c;
               fb_rgb_addr <= next_row_base_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Testbench for framebuffer_scanout: scaled-down framebuffer, index RAM model
// returning addr[7:0], palette RAM array, scoreboard of expected pixels/syncs.
module tb_framebuffer_scanout;

   localparam int W    = 20;
   localparam int H    = 16;
   localparam int HA   = 46;
   localparam int VA   = 36;
   localparam int LAT  = 4;
   localparam int MAXA = W * H - 1;
   localparam logic [23:0] BORDER = 24'h0A0B0C;

   logic        clk;
   logic        reset_n;
   logic        output_enable;
   logic        de_in;
   logic        hsync_in;
   logic        vsync_in;
   logic [16:0] fb_rgb_addr;
   logic [7:0]  fb_rgb_data;
   logic [7:0]  fb_palette_addr;
   logic [23:0] fb_palette_data;
   logic [23:0] rgb_out;
   logic        de_out;
   logic        hsync_out;
   logic        vsync_out;
   logic        frame_start;

   framebuffer_scanout #(
      .FB_WIDTH       (W),
      .FB_HEIGHT      (H),
      .H_ACTIVE       (HA),
      .V_ACTIVE       (VA),
      .FB_RD_LATENCY  (1),
      .PAL_RD_LATENCY (1),
      .BORDER_COLOR   (BORDER)
   ) dut (
      .clk_pixel       (clk),
      .reset_n         (reset_n),
      .output_enable   (output_enable),
      .de_in           (de_in),
      .hsync_in        (hsync_in),
      .vsync_in        (vsync_in),
      .fb_rgb_addr     (fb_rgb_addr),
      .fb_rgb_data     (fb_rgb_data),
      .fb_palette_addr (fb_palette_addr),
      .fb_palette_data (fb_palette_data),
      .rgb_out         (rgb_out),
      .de_out          (de_out),
      .hsync_out       (hsync_out),
      .vsync_out       (vsync_out),
      .frame_start     (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM models, one clock read latency each
   logic [23:0] pal [256];
   always @(posedge clk) fb_rgb_data <= fb_rgb_addr[7:0];
   always @(posedge clk) fb_palette_data <= pal[fb_palette_addr];

   typedef struct packed {
      logic        de;
      logic        hs;
      logic        vs;
      logic [23:0] rgb;
      logic [23:0] rgb_alt;
      logic        alt_ok;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          tick_no = 0;
   bit          armed = 0;
   bit          m_synced = 0;
   bit          m_en = 0;
   bit          m_vs_prev = 0;
   bit          fs_exp = 0;
   bit          pal5_racy = 0;
   logic [23:0] pal5_old;
   logic [23:0] pal5_new;
   int          colored = 0;
   int          fs_count = 0;
   int          max_addr = 0;
   int          last_addr = -1;
   int          de_in_rise_tick = -1;
   int          de_out_rise_tick = -1;

   // One pixel clock: check outputs against the model, then drive the next inputs.
   task automatic tick(input bit rst_n, input bit de, input bit hs, input bit vs,
                       input int px, input int py);
      exp_t o;
      exp_t e;
      exp_t z;
      int   ea;
      int   idx;
      @(negedge clk);
      tick_no++;
      z = '{de: 1'b0, hs: 1'b0, vs: 1'b0, rgb: BORDER, rgb_alt: BORDER, alt_ok: 1'b0};
      if (armed) begin
         n_cmp++;
         if (frame_start !== fs_exp) begin
            n_bad++;
            $display("FAIL frame_start tick %0d: got %b want %b", tick_no, frame_start, fs_exp);
         end
         if (frame_start === 1'b1) fs_count++;
         if (q.size() == LAT) begin
            o = q.pop_front();
            n_cmp++;
            if ({de_out, hsync_out, vsync_out} !== {o.de, o.hs, o.vs}) begin
               n_bad++;
               $display("FAIL syncs tick %0d: got de/hs/vs %b%b%b want %b%b%b", tick_no,
                        de_out, hsync_out, vsync_out, o.de, o.hs, o.vs);
            end
            n_cmp++;
            if (rgb_out !== o.rgb && !(o.alt_ok && rgb_out === o.rgb_alt)) begin
               n_bad++;
               $display("FAIL rgb tick %0d: got %h want %h", tick_no, rgb_out, o.rgb);
            end
            if (de_out === 1'b1 && rgb_out !== BORDER) colored++;
            if (de_out === 1'b1 && de_out_rise_tick < 0) de_out_rise_tick = tick_no;
         end
         if (int'(fb_rgb_addr) > max_addr) max_addr = int'(fb_rgb_addr);
         if (de && m_synced) begin
            // Address the pixel at (px,py) must be read from
            ea = (py < 2 * H) ? (py / 2) * W + ((px < 2 * W) ? px / 2 : W - 1) : MAXA;
            n_cmp++;
            if (fb_rgb_addr !== 17'(ea)) begin
               n_bad++;
               $display("FAIL addr x=%0d y=%0d: got %0d want %0d", px, py, fb_rgb_addr, ea);
            end
            if (px == 2 * W - 1 && py == 2 * H - 1) last_addr = int'(fb_rgb_addr);
         end
      end
      reset_n  = rst_n;
      de_in    = de;
      hsync_in = hs;
      vsync_in = vs;
      if (rst_n && de && de_in_rise_tick < 0) de_in_rise_tick = tick_no;
      if (!rst_n) begin
         foreach (q[i]) q[i] = z;
         e         = z;
         m_vs_prev = 0;
         m_synced  = 0;
         m_en      = 0;
         fs_exp    = 0;
         armed     = 1;
      end else begin
         fs_exp = vs && !m_vs_prev;
         if (fs_exp) begin
            m_synced = 1;
            m_en     = output_enable;
         end
         m_vs_prev = vs;
         e = z;
         e.de = de;
         e.hs = hs;
         e.vs = vs;
         if (de && m_synced && m_en && px < 2 * W && py < 2 * H) begin
            idx = ((py / 2) * W + px / 2) % 256;
            e.rgb = pal[idx];
            if (pal5_racy && idx == 5) begin
               e.rgb     = pal5_old;
               e.rgb_alt = pal5_new;
               e.alt_ok  = 1'b1;
            end
         end
      end
      q.push_back(e);
   endtask

   // One frame: vsync pulse, blanking, vact lines of hact pixels with random hblank/hsync.
   task automatic run_frame(input int hact, input int vact, input int tog_line,
                            input bit tog_val, input int palw_line);
      int hb;
      pal5_racy = (palw_line >= 0);
      pal5_old  = pal[5];
      pal5_new  = 24'($urandom);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      for (int ly = 0; ly < vact; ly++) begin
         if (ly == tog_line) output_enable = tog_val;
         for (int px = 0; px < hact; px++) begin
            if (ly == palw_line && px == hact / 2) pal[5] = pal5_new;
            tick(1'b1, 1'b1, 1'b0, 1'b0, px, ly);
         end
         hb = $urandom_range(6, 10);
         for (int i = 0; i < hb; i++) tick(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 0, 0);
      end
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      pal5_racy = 0;
   endtask

   task automatic random_palette();
      for (int i = 0; i < 256; i++) pal[i] = 24'($urandom);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
      @(posedge clk);
      #1;
      n_cmp++;
      if (rgb_out !== BORDER) begin
         n_bad++; $display("FAIL reset rgb_out: got %h want %h", rgb_out, BORDER);
      end
      n_cmp++;
      if ({de_out, hsync_out, vsync_out, frame_start} !== 4'b0000) begin
         n_bad++; $display("FAIL reset syncs: got %b%b%b%b want 0000", de_out, hsync_out, vsync_out, frame_start);
      end
      n_cmp++;
      if (fb_rgb_addr !== 17'd0) begin
         n_bad++; $display("FAIL reset fb_rgb_addr: got %0d want 0", fb_rgb_addr);
      end
      n_cmp++;
      if (fb_palette_addr !== 8'd0) begin
         n_bad++; $display("FAIL reset fb_palette_addr: got %0d want 0", fb_palette_addr);
      end
   endtask

   task automatic test_image();
      int c0;
      int f0;
      for (int i = 0; i < 256; i++) pal[i] = {8'(i), ~8'(i), 8'(i)};
      output_enable    = 1'b1;
      de_in_rise_tick  = -1;
      de_out_rise_tick = -1;
      c0 = colored;
      f0 = fs_count;
      run_frame(2 * W, 2 * H, -1, 1'b0, -1);
      n_cmp++;
      if (colored - c0 != 4 * W * H) begin
         n_bad++; $display("FAIL image pixels: got %0d want %0d", colored - c0, 4 * W * H);
      end
      n_cmp++;
      if (fs_count - f0 != 1) begin
         n_bad++; $display("FAIL image frame_start pulses: got %0d want 1", fs_count - f0);
      end
      n_cmp++;
      if (de_out_rise_tick - de_in_rise_tick != LAT) begin
         n_bad++; $display("FAIL latency: got %0d want %0d", de_out_rise_tick - de_in_rise_tick, LAT);
      end
   endtask

   task automatic test_boundary();
      int c0;
      random_palette();
      max_addr  = 0;
      last_addr = -1;
      c0 = colored;
      run_frame(2 * W, VA, -1, 1'b0, -1);
      n_cmp++;
      if (max_addr != MAXA) begin
         n_bad++; $display("FAIL max addr: got %0d want %0d", max_addr, MAXA);
      end
      n_cmp++;
      if (last_addr != MAXA) begin
         n_bad++; $display("FAIL last pixel addr: got %0d want %0d", last_addr, MAXA);
      end
      n_cmp++;
      if (colored - c0 != 4 * W * H) begin
         n_bad++; $display("FAIL boundary pixels: got %0d want %0d", colored - c0, 4 * W * H);
      end
   endtask

   task automatic test_wide_line();
      int c0;
      random_palette();
      max_addr = 0;
      c0 = colored;
      run_frame(HA, 2 * H, -1, 1'b0, -1);
      n_cmp++;
      if (colored - c0 != 4 * W * H) begin
         n_bad++; $display("FAIL wide line pixels: got %0d want %0d", colored - c0, 4 * W * H);
      end
      n_cmp++;
      if (max_addr != MAXA) begin
         n_bad++; $display("FAIL wide line max addr: got %0d want %0d", max_addr, MAXA);
      end
   endtask

   task automatic test_enable_toggle();
      int c0;
      random_palette();
      output_enable = 1'b1;
      c0 = colored;
      run_frame(2 * W, 2 * H, 5, 1'b0, -1);
      n_cmp++;
      if (colored - c0 != 4 * W * H) begin
         n_bad++; $display("FAIL disable mid-frame: got %0d want %0d", colored - c0, 4 * W * H);
      end
      c0 = colored;
      run_frame(2 * W, 2 * H, 5, 1'b1, -1);
      n_cmp++;
      if (colored - c0 != 0) begin
         n_bad++; $display("FAIL disabled frame: got %0d want 0", colored - c0);
      end
      c0 = colored;
      run_frame(2 * W, 2 * H, -1, 1'b0, -1);
      n_cmp++;
      if (colored - c0 != 4 * W * H) begin
         n_bad++; $display("FAIL re-enabled frame: got %0d want %0d", colored - c0, 4 * W * H);
      end
   endtask

   task automatic test_palette_race();
      int f0;
      random_palette();
      output_enable = 1'b1;
      f0 = fs_count;
      run_frame(2 * W, 2 * H, -1, 1'b0, 7);
      n_cmp++;
      if (fs_count - f0 != 1) begin
         n_bad++; $display("FAIL palette race frame_start: got %0d want 1", fs_count - f0);
      end
      n_cmp++;
      if (pal[5] !== pal5_new) begin
         n_bad++; $display("FAIL palette write: got %h want %h", pal[5], pal5_new);
      end
   endtask

   task automatic test_midline_reset();
      int c0;
      int f0;
      random_palette();
      output_enable = 1'b1;
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      for (int ly = 0; ly < 3; ly++) begin
         for (int px = 0; px < 2 * W; px++) tick(1'b1, 1'b1, 1'b0, 1'b0, px, ly);
         for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 0, 0);
      end
      for (int px = 0; px < 10; px++) tick(1'b1, 1'b1, 1'b0, 1'b0, px, 3);
      for (int px = 10; px < 13; px++) tick(1'b0, 1'b1, 1'b0, 1'b0, px, 3);
      @(posedge clk);
      #1;
      n_cmp++;
      if (rgb_out !== BORDER || de_out !== 1'b0 || fb_rgb_addr !== 17'd0) begin
         n_bad++;
         $display("FAIL mid-line reset: got rgb %h de %b addr %0d want %h 0 0", rgb_out, de_out, fb_rgb_addr, BORDER);
      end
      c0 = colored;
      f0 = fs_count;
      for (int px = 13; px < 2 * W; px++) tick(1'b1, 1'b1, 1'b0, 1'b0, px, 3);
      for (int ly = 4; ly < 7; ly++) begin
         for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
         for (int px = 0; px < 2 * W; px++) tick(1'b1, 1'b1, 1'b0, 1'b0, px, ly);
      end
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      n_cmp++;
      if (colored != c0) begin
         n_bad++; $display("FAIL colour before resync: got %0d pixels want 0", colored - c0);
      end
      run_frame(2 * W, 2 * H, -1, 1'b0, -1);
      n_cmp++;
      if (fs_count - f0 != 1) begin
         n_bad++; $display("FAIL resync frame_start: got %0d want 1", fs_count - f0);
      end
      n_cmp++;
      if (colored - c0 != 4 * W * H) begin
         n_bad++; $display("FAIL resync image: got %0d want %0d", colored - c0, 4 * W * H);
      end
   endtask

   initial begin
      reset_n       = 1'b0;
      output_enable = 1'b0;
      de_in         = 1'b0;
      hsync_in      = 1'b0;
      vsync_in      = 1'b0;
      for (int i = 0; i < 256; i++) pal[i] = 24'd0;
      test_reset();
      test_image();
      test_boundary();
      test_wide_line();
      test_enable_toggle();
      test_palette_race();
      test_midline_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
